ex_mem_req: RTL and testbench

EX-stage data-memory request unit. It issues load/store requests on the SRAM-like data bus and holds the request through the `addr_ok` handshake. It also generates byte strobes and replicated write data, detects misaligned accesses (ALE), and stalls EX until the request is accepted. It tracks requests cancelled by a pipeline flush so that their late `data_ok` beats can be discarded by the MEM stage downstream.

---
 rtl/ex_mem_req.sv | 133 +++++++++++++
 tb/tb_ex_mem_req.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_req.sv
// EX-stage data-memory request unit: issues SRAM-like bus requests, holds them through
// the addr_ok handshake, and counts flushed-but-accepted requests whose data_ok must be dropped.
module ex_mem_req (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic        ex_op_b,
  input  logic        ex_op_h,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_rkd_value,
  input  logic        ex_excep_in,
  input  logic        mem_excep_ertn,
  input  logic        flush,
  input  logic        mem_allowin,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        ex_ready_go,
  output logic        ex_ale,
  output logic        ex_sram_requed,
  output logic        mem_cancel_data_ok
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, CNCL = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mem_op, is_h, is_w, cnt_full, supp, issue;
  logic       accepted, cnt_inc, cnt_dec;

  function automatic logic [3:0] byte_strobe(input logic b, input logic h, input logic [1:0] a);
    if (b)      byte_strobe = 4'b0001 << a;
    else if (h) byte_strobe = a[1] ? 4'b1100 : 4'b0011;
    else        byte_strobe = 4'b1111;
  endfunction

  function automatic logic [31:0] lane_data(input logic b, input logic h, input logic [31:0] d);
    if (b)      lane_data = {4{d[7:0]}};
    else if (h) lane_data = {2{d[15:0]}};
    else        lane_data = d;
  endfunction

  // Counter never wraps: issue is blocked at 3, so at most one increment can land there.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic inc, input logic dec);
    if (inc && !dec && c != 2'd3) cnt_next = c + 2'd1;
    else if (dec && !inc)         cnt_next = c - 2'd1;
    else                          cnt_next = c;
  endfunction

  assign mem_op   = ex_valid & (ex_mem_re | ex_mem_we);
  assign is_h     = ~ex_op_b & ex_op_h;
  assign is_w     = ~ex_op_b & ~ex_op_h;
  assign ex_ale   = mem_op & ((is_h & ex_addr[0]) | (is_w & (ex_addr[1:0] != 2'b00)));
  assign cnt_full = (cnt_q == 2'd3);
  assign supp     = ex_ale | ex_excep_in | mem_excep_ertn | flush | cnt_full;
  assign issue    = mem_op & ~supp;

  assign data_sram_wr       = ex_mem_we;
  assign data_sram_size     = ex_op_b ? 2'd0 : (ex_op_h ? 2'd1 : 2'd2);
  assign data_sram_wstrb    = ex_mem_we ? byte_strobe(ex_op_b, ex_op_h, ex_addr[1:0]) : 4'b0000;
  assign data_sram_addr     = ex_addr;
  assign data_sram_wdata    = lane_data(ex_op_b, ex_op_h, ex_rkd_value);
  assign ex_sram_requed     = accepted & ~flush;
  assign mem_cancel_data_ok = (cnt_q != 2'd0);
  assign cnt_dec            = data_sram_data_ok & (cnt_q != 2'd0);

  always_comb begin
    state_d       = state_q;
    data_sram_req = 1'b0;
    ex_ready_go   = 1'b0;
    accepted      = 1'b0;
    cnt_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        data_sram_req = issue;
        ex_ready_go   = ~mem_op | (supp & ~cnt_full) | (issue & data_sram_addr_ok);
        accepted      = issue & data_sram_addr_ok;
        if (issue) begin
          if (!data_sram_addr_ok) state_d = REQ;
          else if (!mem_allowin)  state_d = DONE;
        end
      end
      REQ: begin
        data_sram_req = 1'b1;
        ex_ready_go   = data_sram_addr_ok;
        accepted      = data_sram_addr_ok;
        if (flush) begin
          state_d = data_sram_addr_ok ? IDLE : CNCL;
          cnt_inc = data_sram_addr_ok;
        end else if (data_sram_addr_ok) begin
          state_d = mem_allowin ? IDLE : DONE;
        end
      end
      DONE: begin
        ex_ready_go = 1'b1;
        accepted    = 1'b1;
        if (flush) begin
          state_d = IDLE;
          cnt_inc = 1'b1;
        end else if (mem_allowin) begin
          state_d = IDLE;
        end
      end
      CNCL: begin
        data_sram_req = 1'b1;
        if (data_sram_addr_ok) begin
          state_d = IDLE;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_next(cnt_q, cnt_inc, cnt_dec);
    end
  end

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed bench for ex_mem_req: inputs change on the falling edge, outputs checked 1ns later.
module tb_ex_mem_req;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_re, ex_mem_we, ex_op_b, ex_op_h;
  logic [31:0] ex_addr, ex_rkd_value;
  logic        ex_excep_in, mem_excep_ertn, flush, mem_allowin;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        ex_ready_go, ex_ale, ex_sram_requed, mem_cancel_data_ok;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_req dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_op_b(ex_op_b), .ex_op_h(ex_op_h),
    .ex_addr(ex_addr), .ex_rkd_value(ex_rkd_value),
    .ex_excep_in(ex_excep_in), .mem_excep_ertn(mem_excep_ertn), .flush(flush),
    .mem_allowin(mem_allowin),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .ex_ready_go(ex_ready_go), .ex_ale(ex_ale), .ex_sram_requed(ex_sram_requed),
    .mem_cancel_data_ok(mem_cancel_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // req / ready_go / sram_requed / cancel in one call
  task automatic chk_ctl(input string tag, input logic req, input logic rg, input logic rq,
                         input logic cn);
    chk({tag, ".req"},    {31'd0, data_sram_req},      {31'd0, req});
    chk({tag, ".rdy"},    {31'd0, ex_ready_go},        {31'd0, rg});
    chk({tag, ".requed"}, {31'd0, ex_sram_requed},     {31'd0, rq});
    chk({tag, ".cancel"}, {31'd0, mem_cancel_data_ok}, {31'd0, cn});
  endtask

  task automatic op(input logic v, input logic re, input logic we, input logic b, input logic h,
                    input logic [31:0] a, input logic [31:0] d);
    ex_valid = v; ex_mem_re = re; ex_mem_we = we; ex_op_b = b; ex_op_h = h;
    ex_addr = a; ex_rkd_value = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ex_excep_in = 1'b0; mem_excep_ertn = 1'b0; flush = 1'b0; mem_allowin = 1'b1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    cyc(); cyc();
    #1 chk_ctl("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();

    // Zero-wait word store
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'hAABB_CCDD);
    data_sram_addr_ok = 1'b1; mem_allowin = 1'b1;
    #1 chk_ctl("wst", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("wst.wr", {31'd0, data_sram_wr}, 32'd1);
    chk("wst.size", {30'd0, data_sram_size}, 32'd2);
    chk("wst.wstrb", {28'd0, data_sram_wstrb}, 32'hF);
    chk("wst.wdata", data_sram_wdata, 32'hAABB_CCDD);
    chk("wst.addr", data_sram_addr, 32'h1000_0004);
    cyc();

    // Byte store at offset 3: back-to-back issue proves state returned to IDLE
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 32'h1234_5678);
    #1 chk_ctl("bst", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("bst.wstrb", {28'd0, data_sram_wstrb}, 32'h8);
    chk("bst.wdata", data_sram_wdata, 32'h7878_7878);
    chk("bst.size", {30'd0, data_sram_size}, 32'd0);
    cyc();

    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0002, 32'h1234_5678);
    #1 chk_ctl("hld", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("hld.wstrb", {28'd0, data_sram_wstrb}, 32'h0);
    chk("hld.size", {30'd0, data_sram_size}, 32'd1);
    chk("hld.wr", {31'd0, data_sram_wr}, 32'd0);
    chk("hld.ale", {31'd0, ex_ale}, 32'd0);
    cyc();

    // Misaligned accesses
    data_sram_addr_ok = 1'b0;
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0001, 32'h0);
    #1 chk_ctl("ale_h", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ale_h.ale", {31'd0, ex_ale}, 32'd1);
    cyc();
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0002, 32'h0);
    #1 chk_ctl("ale_w", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ale_w.ale", {31'd0, ex_ale}, 32'd1);
    cyc();

    // Exception / ertn / flush block issue in IDLE
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
    ex_excep_in = 1'b1;
    #1 chk_ctl("excep", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    ex_excep_in = 1'b0; mem_excep_ertn = 1'b1;
    #1 chk_ctl("ertn", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    mem_excep_ertn = 1'b0; flush = 1'b1;
    #1 chk_ctl("flush_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    flush = 1'b0;

    // ertn arriving in REQ does not withdraw the request
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0);
    #1 chk_ctl("hold0", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    mem_excep_ertn = 1'b1;
    #1 chk_ctl("hold1", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    mem_excep_ertn = 1'b0; data_sram_addr_ok = 1'b1;
    #1 chk_ctl("hold2", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();

    // addr_ok after 3 wait cycles, then mem_allowin low for 2 cycles
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0);
    data_sram_addr_ok = 1'b0; mem_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl($sformatf("wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    data_sram_addr_ok = 1'b1;
    #1 chk_ctl("wait_ok", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    data_sram_addr_ok = 1'b0;
    #1 chk_ctl("done0", 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    mem_allowin = 1'b1;
    #1 chk_ctl("done1", 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();

    // Flush in REQ -> CNCL, accepted two cycles later
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0);
    #1 chk_ctl("c_iss", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    flush = 1'b1;
    #1 chk_ctl("c_flush", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    flush = 1'b0;
    #1 chk_ctl("c_cncl", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    data_sram_addr_ok = 1'b1;
    #1 chk_ctl("c_acc", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'h0);
    #1 chk_ctl("c_fresh", 1'b1, 1'b1, 1'b1, 1'b1);
    cyc();
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    data_sram_data_ok = 1'b1;
    #1 chk_ctl("c_dok0", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    #1 chk_ctl("c_dok1", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    data_sram_data_ok = 1'b0;
    #1 chk_ctl("c_zero", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();

    // Three flushed accepted loads saturate the counter; the next load stalls
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000 + 32'(i * 4), 32'h0);
      data_sram_addr_ok = 1'b1; mem_allowin = 1'b0;
      #1 chk_ctl($sformatf("s_acc%0d", i), 1'b1, 1'b1, 1'b1, (i != 0));
      cyc();
      data_sram_addr_ok = 1'b0; flush = 1'b1;
      #1 chk_ctl($sformatf("s_fl%0d", i), 1'b0, 1'b1, 1'b0, (i != 0));
      cyc();
      flush = 1'b0;
    end
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'h0);
    data_sram_addr_ok = 1'b1; mem_allowin = 1'b1; data_sram_data_ok = 1'b1;
    #1 chk_ctl("s_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    #1 chk_ctl("s_issue", 1'b1, 1'b1, 1'b1, 1'b1);
    cyc();
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    cyc();
    #1 chk_ctl("s_cnt1", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    #1 chk_ctl("s_cnt0", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
